// File: rtl/bit_column_buffer_if.sv
// -----------------------------------------------------------------------------
// bit_column_buffer_if
// Bus bundle for bit_column_buffer: write stream, extraction request and
// column output.
//   flush      master->slave  discard frame, return to LOAD
//   wr_valid   master->slave  write word offered
//   wr_ready   slave->master  buffer accepting words (LOAD)
//   wr_data    master->slave  WIDTH-bit word
//   full       slave->master  DEPTH words held
//   rd_start   master->slave  one-cycle extraction request
//   col_sel    master->slave  column number, MSB-first
//   busy       slave->master  extraction in progress
//   pipe       slave->master  last completed DEPTH-bit column
//   pipe_valid slave->master  one-cycle pulse when pipe updates
//   sel_err    slave->master  one-cycle pulse, rd_start rejected
//   col_bit / col_bit_valid   serial column bits (only with COLBUF_STREAM_EN)
// -----------------------------------------------------------------------------
interface bit_column_buffer_if #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 64,
   parameter int SEL_W = 5
);
   logic             flush;
   logic             wr_valid;
   logic             wr_ready;
   logic [WIDTH-1:0] wr_data;
   logic             full;
   logic             rd_start;
   logic [SEL_W-1:0] col_sel;
   logic             busy;
   logic [DEPTH-1:0] pipe;
   logic             pipe_valid;
   logic             sel_err;
`ifdef COLBUF_STREAM_EN
   logic             col_bit;
   logic             col_bit_valid;
`endif

   modport master (
      output flush, wr_valid, wr_data, rd_start, col_sel,
`ifdef COLBUF_STREAM_EN
      input  col_bit, col_bit_valid,
`endif
      input  wr_ready, full, busy, pipe, pipe_valid, sel_err
   );

   modport slave (
      input  flush, wr_valid, wr_data, rd_start, col_sel,
`ifdef COLBUF_STREAM_EN
      output col_bit, col_bit_valid,
`endif
      output wr_ready, full, busy, pipe, pipe_valid, sel_err
   );
endinterface

// File: rtl/bit_column_buffer.sv
// -----------------------------------------------------------------------------
// bit_column_buffer
// Stores a frame of DEPTH words (WIDTH bits each) from a valid/ready stream,
// then on request extracts one bit column (bit WIDTH-1-col_sel of every word)
// into a DEPTH-bit vector, one word per cycle.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   bit_column_buffer_if.slave (write stream, request, column output)
// Build option:
//   COLBUF_STREAM_EN  adds serial col_bit/col_bit_valid outputs on the bus.
// -----------------------------------------------------------------------------
module bit_column_buffer #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 64,
   parameter int SEL_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   bit_column_buffer_if.slave bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_FULL    = 2'd1;
   localparam logic [1:0] ST_EXTRACT = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam logic [SEL_W:0]   WIDTH_LIM = (SEL_W + 1)'(WIDTH);
   localparam logic [SEL_W-1:0] MSB_POS   = SEL_W'(WIDTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [1:0]       state_q,      state_d;
   logic [IDX_W-1:0] count_q,      count_d;
   logic [IDX_W-1:0] idx_q,        idx_d;
   logic             drain_q,      drain_d;
   logic [SEL_W-1:0] sel_q,        sel_d;
   logic [DEPTH-1:0] shadow_q,     shadow_d;
   logic [DEPTH-1:0] pipe_q,       pipe_d;
   logic             pipe_valid_q, pipe_valid_d;
   logic             sel_err_q,    sel_err_d;
`ifdef COLBUF_STREAM_EN
   logic             col_bit_q,       col_bit_d;
   logic             col_bit_valid_q, col_bit_valid_d;
`endif

   logic             wr_en;
   logic [WIDTH-1:0] rd_word;
   logic [SEL_W-1:0] bit_pos;
   logic             col_bit_now;

   // flush wins over a simultaneous write
   assign wr_en       = (state_q == ST_LOAD) && bus.wr_valid && !bus.flush && !rst;
   assign rd_word     = mem_q[idx_q];
   assign bit_pos     = MSB_POS - sel_q;
   assign col_bit_now = rd_word[bit_pos];

   // Frame storage carries no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[count_q] <= bus.wr_data;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      idx_d        = idx_q;
      drain_d      = drain_q;
      sel_d        = sel_q;
      shadow_d     = shadow_q;
      pipe_d       = pipe_q;
      pipe_valid_d = 1'b0;
      sel_err_d    = 1'b0;
`ifdef COLBUF_STREAM_EN
      col_bit_d       = 1'b0;
      col_bit_valid_d = 1'b0;
`endif
      if (bus.flush) begin
         state_d = ST_LOAD;
         count_d = '0;
         idx_d   = '0;
         drain_d = 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (bus.wr_valid) begin
                  if (count_q == LAST_IDX) begin
                     state_d = ST_FULL;
                     count_d = '0;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
               if (bus.rd_start) begin
                  sel_err_d = 1'b1;
               end
            end
            ST_FULL: begin
               if (bus.rd_start) begin
                  if ({1'b0, bus.col_sel} < WIDTH_LIM) begin
                     sel_d   = bus.col_sel;
                     idx_d   = '0;
                     drain_d = 1'b0;
                     state_d = ST_EXTRACT;
                  end else begin
                     sel_err_d = 1'b1;
                  end
               end
            end
            ST_EXTRACT: begin
               // One extra cycle after the last word publishes the shadow,
               // giving the rd_start-to-pipe latency of DEPTH+1 edges.
               if (drain_q) begin
                  pipe_d       = shadow_q;
                  pipe_valid_d = 1'b1;
                  drain_d      = 1'b0;
                  state_d      = ST_FULL;
               end else begin
                  shadow_d[idx_q] = col_bit_now;
`ifdef COLBUF_STREAM_EN
                  col_bit_d       = col_bit_now;
                  col_bit_valid_d = 1'b1;
`endif
                  if (idx_q == LAST_IDX) begin
                     drain_d = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_LOAD;
               count_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         count_q      <= '0;
         idx_q        <= '0;
         drain_q      <= 1'b0;
         sel_q        <= '0;
         shadow_q     <= '0;
         pipe_q       <= '0;
         pipe_valid_q <= 1'b0;
         sel_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
         drain_q      <= drain_d;
         sel_q        <= sel_d;
         shadow_q     <= shadow_d;
         pipe_q       <= pipe_d;
         pipe_valid_q <= pipe_valid_d;
         sel_err_q    <= sel_err_d;
      end
   end

`ifdef COLBUF_STREAM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         col_bit_q       <= 1'b0;
         col_bit_valid_q <= 1'b0;
      end else begin
         col_bit_q       <= col_bit_d;
         col_bit_valid_q <= col_bit_valid_d;
      end
   end

   assign bus.col_bit       = col_bit_q;
   assign bus.col_bit_valid = col_bit_valid_q;
`endif

   assign bus.wr_ready   = (state_q == ST_LOAD);
   assign bus.full       = (state_q == ST_FULL) || (state_q == ST_EXTRACT);
   assign bus.busy       = (state_q == ST_EXTRACT);
   assign bus.pipe       = pipe_q;
   assign bus.pipe_valid = pipe_valid_q;
   assign bus.sel_err    = sel_err_q;
endmodule

// File: tb/tb_bit_column_buffer.sv
// -----------------------------------------------------------------------------
// tb_bit_column_buffer
// Self-checking bench for bit_column_buffer. A frame model (tb_mem) produces
// the expected column, pushed to exp_q on each accepted rd_start and popped
// when pipe_valid appears. Serial-output checks compile only with
// COLBUF_STREAM_EN.
// -----------------------------------------------------------------------------
module tb_bit_column_buffer;
   localparam int W  = 25;
   localparam int D  = 64;
   localparam int SW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bit_column_buffer_if #(.WIDTH(W), .DEPTH(D), .SEL_W(SW)) bus ();

   bit_column_buffer #(.WIDTH(W), .DEPTH(D), .SEL_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;
   int unsigned t_start;
   int unsigned pv_cyc;
   int          pv_count = 0;

   logic [W-1:0] tb_mem [D];
   logic [D-1:0] exp_q [$];
   logic [D-1:0] last_pipe;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.pipe_valid === 1'b1) pv_count++;

`ifdef COLBUF_STREAM_EN
   int sv_cnt, sv_ones, sv_first, sv_last;
   always @(negedge clk) begin
      if (bus.col_bit_valid === 1'b1) begin
         sv_cnt++;
         if (bus.col_bit === 1'b1) sv_ones++;
         if (sv_first < 0) sv_first = int'(cyc);
         sv_last = int'(cyc);
      end
   end
`endif

   function automatic logic [D-1:0] model_col(input int sel);
      logic [D-1:0] r;
      logic [W-1:0] w;
      for (int n = 0; n < D; n++) begin
         w    = tb_mem[n];
         r[n] = w[W-1-sel];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask

   task automatic load_frame();
      for (int i = 0; i < D; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = tb_mem[i];
         tick();
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic start_extract(input int sel);
      exp_q.push_back(model_col(sel));
      bus.col_sel  = SW'(sel);
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      t_start = cyc;
   endtask

   // Scoreboard pop: waits (bounded) for pipe_valid, then compares latency,
   // column value and pulse width against the queued expectation.
   task automatic sb_collect(input string name);
      logic [D-1:0] exp_v;
      @(negedge clk);
      while (bus.pipe_valid !== 1'b1 && (cyc - t_start) < 200) @(negedge clk);
      exp_v = exp_q.pop_front();
      last_pipe = exp_v;
      checks++;
      if (bus.pipe_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: pipe_valid=%b required 1 within 200 cycles", name, bus.pipe_valid);
         return;
      end
      pv_cyc = cyc;
      checks++;
      if ((cyc - t_start) !== 65) begin
         errors++;
         $display("FAIL %s_latency: got %0d required 65", name, cyc - t_start);
      end
      checks++;
      if (bus.pipe !== exp_v) begin
         errors++;
         $display("FAIL %s_pipe: got %h required %h", name, bus.pipe, exp_v);
      end
      @(negedge clk);
      checks++;
      if (bus.pipe_valid !== 1'b0 || bus.busy !== 1'b0 || bus.full !== 1'b1) begin
         errors++;
         $display("FAIL %s_after: pv=%b busy=%b full=%b required 0 0 1", name,
                  bus.pipe_valid, bus.busy, bus.full);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.wr_ready, bus.full, bus.busy, bus.pipe_valid, bus.sel_err} !== 5'b10000 ||
          bus.pipe !== '0) begin
         errors++;
         $display("FAIL reset: rdy/full/busy/pv/err=%b%b%b%b%b pipe=%h required 10000 pipe=0",
                  bus.wr_ready, bus.full, bus.busy, bus.pipe_valid, bus.sel_err, bus.pipe);
      end
   endtask

   task automatic test_first_column();
      for (int i = 0; i < D; i++) tb_mem[i] = W'(i);
      load_frame();
      checks++;
      if (bus.full !== 1'b1 || bus.wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_full: full=%b wr_ready=%b required 1 0", bus.full, bus.wr_ready);
      end
      start_extract(24);
      checks++;
      if (64'hAAAA_AAAA_AAAA_AAAA !== exp_q[0] || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL col24_busy: busy=%b required 1", bus.busy);
      end
      sb_collect("col24");
   endtask

   task automatic test_second_column();
      start_extract(0);
      repeat (10) tick();
      // rd_start during extraction must be ignored silently
      bus.col_sel  = SW'(25);
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.sel_err !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL extract_rdstart: sel_err=%b busy=%b required 0 1", bus.sel_err, bus.busy);
      end
      sb_collect("col0");
   endtask

   task automatic test_sel_err();
      bus.col_sel  = SW'(25);
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL sel25: sel_err=%b busy=%b required 1 0", bus.sel_err, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.sel_err !== 1'b0 || bus.pipe !== last_pipe || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL sel25_after: sel_err=%b pipe=%h busy=%b required 0 %h 0",
                  bus.sel_err, bus.pipe, bus.busy, last_pipe);
      end
      #1;
      do_flush();
      for (int i = 0; i < D; i++) tb_mem[i] = W'($urandom);
      for (int i = 0; i < 10; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = tb_mem[i];
         tick();
      end
      bus.wr_valid = 1'b0;
      bus.col_sel  = SW'(5);
      bus.rd_start = 1'b1;
      tick();
      bus.rd_start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.sel_err !== 1'b1 || bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL load_rdstart: sel_err=%b wr_ready=%b busy=%b required 1 1 0",
                  bus.sel_err, bus.wr_ready, bus.busy);
      end
      #1;
      for (int i = 10; i < D; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = tb_mem[i];
         tick();
         if (i == D - 2) begin
            checks++;
            if (bus.full !== 1'b0) begin
               errors++;
               $display("FAIL count10_early: full=%b required 0 after 63 words", bus.full);
            end
         end
      end
      bus.wr_valid = 1'b0;
      checks++;
      if (bus.full !== 1'b1) begin
         errors++;
         $display("FAIL count10_full: full=%b required 1 after 64 words", bus.full);
      end
      start_extract(7);
      sb_collect("col7");
   endtask

   task automatic test_overrun();
      int acc;
      int full_at;
      acc = 0;
      full_at = -1;
      do_flush();
      for (int i = 0; i < D + 2; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = (i < D) ? W'($urandom) : ~tb_mem[i-D];
         if (bus.wr_ready === 1'b1) begin
            tb_mem[acc] = bus.wr_data;
            acc++;
         end
         tick();
         if (full_at < 0 && bus.full === 1'b1) full_at = i;
      end
      bus.wr_valid = 1'b0;
      checks++;
      if (acc !== 64 || full_at !== 63 || bus.wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL overrun: accepted=%0d full_at=%0d wr_ready=%b required 64 63 0",
                  acc, full_at, bus.wr_ready);
      end
      start_extract(int'($urandom_range(0, 24)));
      sb_collect("overrun_col");
   endtask

   task automatic test_flush_mid_extract();
      int pv_before;
      pv_before = pv_count;
      start_extract(12);
      void'(exp_q.pop_back());
      repeat (29) tick();
      do_flush();
      @(negedge clk);
      checks++;
      if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0 || bus.full !== 1'b0 || bus.pipe !== last_pipe) begin
         errors++;
         $display("FAIL flush: wr_ready=%b busy=%b full=%b pipe=%h required 1 0 0 %h",
                  bus.wr_ready, bus.busy, bus.full, bus.pipe, last_pipe);
      end
      repeat (70) @(negedge clk);
      checks++;
      if (pv_count !== pv_before || bus.pipe !== last_pipe) begin
         errors++;
         $display("FAIL flush_nopv: pulses=%0d pipe=%h required %0d %h",
                  pv_count, bus.pipe, pv_before, last_pipe);
      end
      #1;
      for (int i = 0; i < D; i++) tb_mem[i] = W'($urandom);
      load_frame();
      start_extract(19);
      sb_collect("reload_col19");
   endtask

   task automatic test_stream();
      for (int i = 0; i < D; i++) tb_mem[i] = '1;
      do_flush();
      load_frame();
`ifdef COLBUF_STREAM_EN
      sv_cnt = 0;
      sv_ones = 0;
      sv_first = -1;
      sv_last = -1;
`endif
      start_extract(3);
      sb_collect("ones_col3");
`ifdef COLBUF_STREAM_EN
      checks++;
      if (sv_cnt !== 64 || sv_ones !== 64 || (sv_last - sv_first) !== 63 ||
          sv_last !== int'(pv_cyc) - 1 || bus.col_bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream: cnt=%0d ones=%0d span=%0d last=%0d pv=%0d cbv=%b required 64 64 63 pv-1 0",
                  sv_cnt, sv_ones, sv_last - sv_first, sv_last, pv_cyc, bus.col_bit_valid);
      end
`endif
   endtask

   initial begin
      rst          = 1'b1;
      bus.flush    = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
      bus.rd_start = 1'b0;
      bus.col_sel  = '0;
      test_reset();
      #1;
      test_first_column();
      #1;
      test_second_column();
      #1;
      test_sel_err();
      #1;
      test_overrun();
      #1;
      test_flush_mid_extract();
      #1;
      test_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
